// File: rtl/id_ex_stage_buf.sv
// ID/EX elastic stage: main + skid register pair with valid/ready on both sides,
// synchronous flush that squashes held entries, and a saturating EX-idle counter.
module id_ex_stage_buf #(
  parameter int CTRL_W = 8,
  parameter int WORD   = 32,
  parameter int NDATA  = 3,
  parameter int RWIDTH = 5,
  parameter int NREG   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [CTRL_W-1:0]       in_ctrl_i,
  input  logic [NDATA*WORD-1:0]   in_data_i,
  input  logic [NREG*RWIDTH-1:0]  in_regs_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [CTRL_W-1:0]       out_ctrl_o,
  output logic [NDATA*WORD-1:0]   out_data_o,
  output logic [NREG*RWIDTH-1:0]  out_regs_o,
  output logic [1:0]              occupancy_o,
  output logic [CNT_W-1:0]        bubble_count_o
);

  typedef struct packed {
    logic [CTRL_W-1:0]      ctrl;
    logic [NDATA*WORD-1:0]  data;
    logic [NREG*RWIDTH-1:0] regs;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, in_ent;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             in_fire, out_fire;

  assign in_ent     = {in_ctrl_i, in_data_i, in_regs_i};

  // Handshake outputs decode registered state only.
  assign in_ready_o     = (state_q != TWO);
  assign out_valid_o    = (state_q != EMPTY);
  assign in_fire        = in_valid_i & in_ready_o;
  assign out_fire       = out_valid_o & out_ready_i;
  assign out_ctrl_o     = main_q.ctrl;
  assign out_data_o     = main_q.data;
  assign out_regs_o     = main_q.regs;
  assign occupancy_o    = state_q;
  assign bubble_count_o = bubble_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        main_d  = in_ent;
        state_d = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_ent;
        end else if (in_fire) begin
          skid_d  = in_ent;
          state_d = TWO;
        end else if (out_fire) begin
          main_d.ctrl = '0;
          state_d     = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        main_d      = skid_q;
        skid_d.ctrl = '0;
        state_d     = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides everything; ctrl is zeroed so squashed entries carry no side effects.
    if (flush_i) begin
      state_d     = EMPTY;
      main_d      = main_q;
      main_d.ctrl = '0;
      skid_d      = skid_q;
      skid_d.ctrl = '0;
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (out_ready_i && !out_valid_o && (bubble_q != {CNT_W{1'b1}}))
      bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Bench for id_ex_stage_buf: directed table, saturation/async-reset sequences,
// then random traffic against a two-slot queue model.
module tb_id_ex_stage_buf;
  localparam int CW = 8, W = 32, ND = 3, RW = 5, NR = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             flush, in_valid, out_ready;
  logic [CW-1:0]    in_ctrl;
  logic [ND*W-1:0]  in_data;
  logic [NR*RW-1:0] in_regs;
  logic             in_ready, out_valid, in_ready4, out_valid4;
  logic [CW-1:0]    out_ctrl, out_ctrl4;
  logic [ND*W-1:0]  out_data, out_data4;
  logic [NR*RW-1:0] out_regs, out_regs4;
  logic [1:0]       occ, occ4;
  logic [15:0]      bub;
  logic [3:0]       bub4;

  id_ex_stage_buf #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ctrl_i(in_ctrl),
    .in_data_i(in_data), .in_regs_i(in_regs),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl),
    .out_data_o(out_data), .out_regs_o(out_regs),
    .occupancy_o(occ), .bubble_count_o(bub));

  id_ex_stage_buf #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready4), .in_ctrl_i(in_ctrl),
    .in_data_i(in_data), .in_regs_i(in_regs),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl4),
    .out_data_o(out_data4), .out_regs_o(out_regs4),
    .occupancy_o(occ4), .bubble_count_o(bub4));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic iv; logic [7:0] ic; logic ordy; logic fl;
    logic ev; logic [7:0] ec; logic [1:0] eocc; logic eir; int eb;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [7:0] ic, logic ordy, logic fl,
                              logic ev, logic [7:0] ec, logic [1:0] eocc, logic eir, int eb);
    vec_t v;
    v.iv = iv; v.ic = ic; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ec = ec; v.eocc = eocc; v.eir = eir; v.eb = eb;
    return v;
  endfunction

  typedef struct packed {
    logic [CW-1:0]    c;
    logic [ND*W-1:0]  d;
    logic [NR*RW-1:0] r;
  } ent_t;

  vec_t tbl[$];
  ent_t q[$];
  ent_t e;
  int   m16, m4;
  logic mi, mo;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    flush = 0; in_valid = 0; out_ready = 0; in_ctrl = '0; in_data = '0; in_regs = '0;

    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 8'h80 | 8'(k), 1, 0, 1, 8'h80 | 8'(k), 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(1, 8'h90, 0, 0, 1, 8'h90, 1, 1, 1));
    tbl.push_back(mk(1, 8'h91, 0, 0, 1, 8'h90, 2, 0, 1));
    tbl.push_back(mk(1, 8'h92, 0, 0, 1, 8'h90, 2, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h91, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 2));
    tbl.push_back(mk(1, 8'hA0, 0, 0, 1, 8'hA0, 1, 1, 2));
    tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 8'hA0, 2, 0, 2));
    tbl.push_back(mk(1, 8'hA2, 0, 1, 0, 8'h00, 0, 1, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 3));
    tbl.push_back(mk(1, 8'hA3, 1, 0, 1, 8'hA3, 1, 1, 4));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'hA3, 1, 1, 4));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 4));

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occ, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_data", out_data, 0);
    chk("rst_bubble", bub, 0);
    rst_n = 1;

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_ctrl = tbl[i].ic; in_data = {64'h0, 24'h0, tbl[i].ic};
      out_ready = tbl[i].ordy; flush = tbl[i].fl;
      @(posedge clk); @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ctrl", i), out_ctrl, tbl[i].ec);
      chk($sformatf("tbl%0d_occ", i), occ, tbl[i].eocc);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].eir);
      chk($sformatf("tbl%0d_bubble", i), bub, tbl[i].eb);
      chk($sformatf("tbl%0d_bubble4", i), bub4, tbl[i].eb);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data0", i), out_data[31:0], {24'h0, tbl[i].ec});
    end
    flush = 0;

    // Idle-but-ready run long enough to saturate the 4-bit counter.
    in_valid = 0; out_ready = 1;
    repeat (21) begin @(posedge clk); @(negedge clk); end
    chk("sat_bubble4", bub4, 15);
    chk("sat_bubble16", bub, 25);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("sat_bubble4_hold", bub4, 15);

    // Async reset while two entries are held.
    in_valid = 1; in_ctrl = 8'hC0; out_ready = 0;
    @(posedge clk); @(negedge clk);
    in_ctrl = 8'hC1; in_data = {96{1'b1}}; in_regs = '1;
    @(posedge clk); #2;
    chk("pre_arst_occ", occ, 2);
    rst_n = 0; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occ, 0);
    chk("arst_ctrl", out_ctrl, 0);
    chk("arst_data", out_data, 0);
    chk("arst_regs", out_regs, 0);
    chk("arst_bubble", bub, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1; in_ctrl = 8'hC5; in_data = {64'h0, 32'h55}; in_regs = 15'h1234;
    @(posedge clk); @(negedge clk);
    chk("post_arst_valid", out_valid, 1);
    chk("post_arst_ctrl", out_ctrl, 8'hC5);
    chk("post_arst_data0", out_data[31:0], 32'h55);
    chk("post_arst_regs", out_regs, 15'h1234);
    in_valid = 0;

    // Random traffic against a two-slot FIFO model.
    rst_n = 0; #1; rst_n = 1;
    q.delete(); m16 = 0; m4 = 0;
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_valid", out_valid, q.size() > 0);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      chk("rnd_occ", occ, q.size());
      chk("rnd_bubble", bub, m16);
      chk("rnd_bubble4", bub4, m4);
      if (q.size() > 0) begin
        chk("rnd_ctrl", out_ctrl, q[0].c);
        chk("rnd_data", out_data, q[0].d);
        chk("rnd_regs", out_regs, q[0].r);
      end else begin
        chk("rnd_ctrl_idle", out_ctrl, 0);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_ctrl   = 8'($urandom);
      in_data   = {$urandom, $urandom, $urandom};
      in_regs   = 15'($urandom);
      mi = in_valid && (q.size() < 2);
      mo = out_ready && (q.size() > 0);
      if (out_ready && q.size() == 0) begin
        if (m16 < 65535) m16++;
        if (m4 < 15) m4++;
      end
      e = {in_ctrl, in_data, in_regs};
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (mo) void'(q.pop_front());
        if (mi) q.push_back(e);
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
